beta_mem_arbiter: RTL and testbench
===================================

# beta_mem_arbiter

Single-outstanding arbiter that shares one unified memory bus between the core's three memory requesters: the instruction-fetch port, the data read port and the data write port. It sits between the core top level and the external memory. Data traffic has fixed priority over fetch. A starvation counter guarantees forward progress for instruction fetch. Request payloads are latched at selection, so the memory side sees stable signals regardless of requester behaviour.

## Interface
Parameters:
- DataWidth, 32, data bus width
- AddressWidth, 32, address width
- StarveLimit, 4, consecutive lost arbitrations after which a pending fetch wins (≥1)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- instr_req_i / instr_addr_i  in  1 / AddressWidth  fetch request, address
- instr_ready_o / instr_valid_o  out  1 / 1  fetch accepted, fetch data valid
- instr_rdata_o  out  DataWidth  fetch data
- rdata_req_i / rdata_addr_i / rdata_strb_i  in  1 / AddressWidth / DataWidth/8  load request
- rdata_ready_o / rdata_valid_o  out  1 / 1  load accepted, load data valid
- rdata_data_o  out  DataWidth  load data
- wdata_req_i / wdata_addr_i / wdata_data_i / wdata_strb_i  in  1 / AddressWidth / DataWidth / DataWidth/8  store request
- wdata_ready_o / wdata_valid_o  out  1 / 1  store accepted, store acknowledged
- mem_req_o / mem_we_o  out  1 / 1  bus request, write enable
- mem_addr_o / mem_wdata_o / mem_strb_o  out  AddressWidth / DataWidth / DataWidth/8  latched payload
- mem_gnt_i / mem_rvalid_i  in  1 / 1  bus grant, response valid (read data or write ack)
- mem_rdata_i  in  DataWidth  read data
- arb_busy_o  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: if any request is pending, latch the winner's owner, address, data, strb and we (fetch strb = all ones) → ADDR.
  - ADDR: mem_req_o=1. On mem_gnt_i → RESP. On mem_gnt_i & mem_rvalid_i in the same cycle → IDLE.
  - RESP: on mem_rvalid_i → IDLE.
- Priority: wdata > rdata > instr. Exception: when instr_req_i=1 and starve_cnt==StarveLimit, instr wins.
- starve_cnt:
  - increments (saturating at StarveLimit) at each IDLE selection where instr_req_i=1 but instr loses;
  - clears when instr wins;
  - holds otherwise.
- <owner>_ready_o = mem_gnt_i while in ADDR. Only the owner sees it; the other ready outputs are 0.
- <owner>_valid_o = mem_rvalid_i while in RESP, or in ADDR when gnt and rvalid coincide.
- Read data outputs forward mem_rdata_i combinationally to all three read-data ports. Data is meaningful only with the matching valid.
- A requester dropping req after latching does not abort: the transaction completes and valid still pulses.
- mem_rvalid_i in IDLE, and mem_gnt_i outside ADDR, are ignored.

## Timing
- Reset (async, immediate): state=IDLE, starve_cnt=0, latched payload=0; all outputs 0 except the combinational rdata forwards.
- Request in IDLE at cycle N → mem_req_o=1 from N+1. mem_req_o, addr, wdata, strb and we are stable until the gnt cycle.
- Minimum transaction length: 2 cycles (IDLE + ADDR with gnt & rvalid together). Typical: 3 cycles. An IDLE cycle always separates transactions.
- ready and valid are single-cycle pulses, combinational from mem_gnt_i / mem_rvalid_i.
- Reset mid-transaction discards the outstanding response. A late rvalid after reset is ignored.
- Simultaneous requests are resolved only in IDLE. Requests arriving in ADDR or RESP wait.

## Structure
- beta_pkg gains:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ADDR, ARB_RESP};
  - typedef enum arb_owner_t {OWN_NONE, OWN_INSTR, OWN_RDATA, OWN_WDATA}.
- Sub-module beta_arb_priority: combinational winner select from the three reqs and the starve flag, outputs arb_owner_t.
- Everything else (FSM, starve counter, payload latch, response steering) lives in beta_mem_arbiter.

## Test plan
- Fetch only, addr 0x100, gnt at N+1, rvalid at N+2 with 0xDEADBEEF → instr_ready_o at N+1, instr_valid_o at N+2, instr_rdata_o=0xDEADBEEF; other ports silent.
- instr, rdata and wdata all asserted at N → wdata transaction first (mem_we_o=1), then rdata, then instr. wdata_valid_o, rdata_valid_o and instr_valid_o pulse in that order.
- wdata_req_i held high continuously with instr_req_i high, StarveLimit=4 → fetch wins the 5th arbitration; starve_cnt returns to 0.
- mem_gnt_i withheld 10 cycles in ADDR → mem_req_o, mem_addr_o and mem_wdata_o constant throughout; no ready pulses.
- gnt and rvalid in the same ADDR cycle for a load → rdata_ready_o and rdata_valid_o both pulse that cycle; state IDLE next cycle.
- rstn_i asserted in RESP, then late mem_rvalid_i=1 → all valid outputs 0, state IDLE, arb_busy_o=0.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared types for the beta memory arbiter: FSM state and bus-owner encodings.
package beta_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_RDATA,
    OWN_WDATA
  } arb_owner_t;

endpackage

// File: rtl/beta_arb_priority.sv
// Combinational winner select: store > load > fetch, unless fetch is starved.
module beta_arb_priority
  import beta_pkg::*;
(
  input  logic       instr_req,
  input  logic       rdata_req,
  input  logic       wdata_req,
  input  logic       starve,
  output arb_owner_t winner
);

  always_comb begin
    winner = OWN_NONE;
    if (instr_req && starve) begin
      winner = OWN_INSTR;
    end else if (wdata_req) begin
      winner = OWN_WDATA;
    end else if (rdata_req) begin
      winner = OWN_RDATA;
    end else if (instr_req) begin
      winner = OWN_INSTR;
    end
  end

endmodule

// File: rtl/beta_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between fetch, load and store.
// Payload is latched at selection so the bus sees stable signals until grant.
//
// state    | meaning
// ARB_IDLE | no transaction; pick a winner and latch its payload
// ARB_ADDR | mem_req_o high, waiting for grant (rvalid may coincide)
// ARB_RESP | granted, waiting for rvalid
module beta_mem_arbiter
  import beta_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int StarveLimit  = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      instr_req_i,
  input  logic [AddressWidth-1:0]   instr_addr_i,
  output logic                      instr_ready_o,
  output logic                      instr_valid_o,
  output logic [DataWidth-1:0]      instr_rdata_o,
  input  logic                      rdata_req_i,
  input  logic [AddressWidth-1:0]   rdata_addr_i,
  input  logic [DataWidth/8-1:0]    rdata_strb_i,
  output logic                      rdata_ready_o,
  output logic                      rdata_valid_o,
  output logic [DataWidth-1:0]      rdata_data_o,
  input  logic                      wdata_req_i,
  input  logic [AddressWidth-1:0]   wdata_addr_i,
  input  logic [DataWidth-1:0]      wdata_data_i,
  input  logic [DataWidth/8-1:0]    wdata_strb_i,
  output logic                      wdata_ready_o,
  output logic                      wdata_valid_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [AddressWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]      mem_wdata_o,
  output logic [DataWidth/8-1:0]    mem_strb_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DataWidth-1:0]      mem_rdata_i,
  output logic                      arb_busy_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int CntWidth  = $clog2(StarveLimit + 1);

  arb_state_t                state_q, state_d;
  arb_owner_t                owner_q, winner;
  logic [AddressWidth-1:0]   addr_q, sel_addr;
  logic [DataWidth-1:0]      wdata_q;
  logic [StrbWidth-1:0]      strb_q, sel_strb;
  logic                      we_q;
  logic [CntWidth-1:0]       starve_cnt;
  logic                      starve;
  logic                      select;
  logic                      gnt_hit;
  logic                      rsp_hit;

  assign starve = (starve_cnt == CntWidth'(StarveLimit));
  assign select = (state_q == ARB_IDLE) && (winner != OWN_NONE);

  beta_arb_priority u_priority (
    .instr_req (instr_req_i),
    .rdata_req (rdata_req_i),
    .wdata_req (wdata_req_i),
    .starve    (starve),
    .winner    (winner)
  );

  always_comb begin
    sel_addr = instr_addr_i;
    sel_strb = '1;
    case (winner)
      OWN_RDATA: begin
        sel_addr = rdata_addr_i;
        sel_strb = rdata_strb_i;
      end
      OWN_WDATA: begin
        sel_addr = wdata_addr_i;
        sel_strb = wdata_strb_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (winner != OWN_NONE) state_d = ARB_ADDR;
      ARB_ADDR: if (mem_gnt_i) state_d = mem_rvalid_i ? ARB_IDLE : ARB_RESP;
      ARB_RESP: if (mem_rvalid_i) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      we_q       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (select) begin
        owner_q <= winner;
        addr_q  <= sel_addr;
        wdata_q <= (winner == OWN_WDATA) ? wdata_data_i : '0;
        strb_q  <= sel_strb;
        we_q    <= (winner == OWN_WDATA);
        if (winner == OWN_INSTR) begin
          starve_cnt <= '0;
        end else if (instr_req_i && !starve) begin
          starve_cnt <= starve_cnt + CntWidth'(1);
        end
      end
    end
  end

  // Handshake pulses come straight from the bus so the owner sees them the same cycle.
  assign gnt_hit = (state_q == ARB_ADDR) && mem_gnt_i;
  assign rsp_hit = ((state_q == ARB_RESP) && mem_rvalid_i) || (gnt_hit && mem_rvalid_i);

  assign instr_ready_o = gnt_hit && (owner_q == OWN_INSTR);
  assign rdata_ready_o = gnt_hit && (owner_q == OWN_RDATA);
  assign wdata_ready_o = gnt_hit && (owner_q == OWN_WDATA);
  assign instr_valid_o = rsp_hit && (owner_q == OWN_INSTR);
  assign rdata_valid_o = rsp_hit && (owner_q == OWN_RDATA);
  assign wdata_valid_o = rsp_hit && (owner_q == OWN_WDATA);

  assign instr_rdata_o = mem_rdata_i;
  assign rdata_data_o  = mem_rdata_i;

  assign mem_req_o   = (state_q == ARB_ADDR);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_strb_o  = strb_q;
  assign arb_busy_o  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Directed bench for beta_mem_arbiter: priority, starvation, stall, fast path, reset.
module tb_beta_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        instr_req_i, rdata_req_i, wdata_req_i;
  logic [31:0] instr_addr_i, rdata_addr_i, wdata_addr_i, wdata_data_i;
  logic [3:0]  rdata_strb_i, wdata_strb_i;
  logic        instr_ready_o, instr_valid_o, rdata_ready_o, rdata_valid_o;
  logic        wdata_ready_o, wdata_valid_o;
  logic [31:0] instr_rdata_o, rdata_data_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, arb_busy_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_strb_o;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] O_INSTR = 3'b100;
  localparam logic [2:0] O_RDATA = 3'b010;
  localparam logic [2:0] O_WDATA = 3'b001;

  always #5 clk_i = ~clk_i;

  beta_mem_arbiter dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .instr_req_i  (instr_req_i),
    .instr_addr_i (instr_addr_i),
    .instr_ready_o(instr_ready_o),
    .instr_valid_o(instr_valid_o),
    .instr_rdata_o(instr_rdata_o),
    .rdata_req_i  (rdata_req_i),
    .rdata_addr_i (rdata_addr_i),
    .rdata_strb_i (rdata_strb_i),
    .rdata_ready_o(rdata_ready_o),
    .rdata_valid_o(rdata_valid_o),
    .rdata_data_o (rdata_data_o),
    .wdata_req_i  (wdata_req_i),
    .wdata_addr_i (wdata_addr_i),
    .wdata_data_i (wdata_data_i),
    .wdata_strb_i (wdata_strb_i),
    .wdata_ready_o(wdata_ready_o),
    .wdata_valid_o(wdata_valid_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_strb_o   (mem_strb_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .arb_busy_o   (arb_busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1 in IDLE with requests set; returns at posedge+1 back in IDLE.
  task automatic txn(input string tag, input logic [2:0] own, input logic [31:0] addr,
                     input logic we, input logic [31:0] wd, input logic [3:0] strb,
                     input logic [31:0] rd);
    #1 chk({tag, "_idle"}, arb_busy_o, 0);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b1;
    #1;
    chk({tag, "_req"}, mem_req_o, 1);
    chk({tag, "_addr"}, mem_addr_o, addr);
    chk({tag, "_we"}, mem_we_o, we);
    chk({tag, "_strb"}, mem_strb_o, strb);
    if (we) chk({tag, "_wdata"}, mem_wdata_o, wd);
    chk({tag, "_ready"}, {instr_ready_o, rdata_ready_o, wdata_ready_o}, own);
    chk({tag, "_valid_early"}, {instr_valid_o, rdata_valid_o, wdata_valid_o}, 0);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = rd;
    #1;
    chk({tag, "_valid"}, {instr_valid_o, rdata_valid_o, wdata_valid_o}, own);
    chk({tag, "_ready_late"}, {instr_ready_o, rdata_ready_o, wdata_ready_o}, 0);
    if (own == O_INSTR) chk({tag, "_irdata"}, instr_rdata_o, rd);
    if (own == O_RDATA) chk({tag, "_rdata"}, rdata_data_o, rd);
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0;
    {instr_req_i, rdata_req_i, wdata_req_i} = '0;
    instr_addr_i = '0; rdata_addr_i = '0; wdata_addr_i = '0; wdata_data_i = '0;
    rdata_strb_i = '0; wdata_strb_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h5A5A_5A5A;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", arb_busy_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_payload", {mem_we_o, mem_addr_o, mem_strb_o}, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_fwd", rdata_data_o, 32'h5A5A_5A5A);
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // grant in IDLE with nothing pending is ignored
    mem_gnt_i = 1'b1;
    #1;
    chk("idle_gnt_ready", {instr_ready_o, rdata_ready_o, wdata_ready_o}, 0);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    chk("idle_gnt_busy", arb_busy_o, 0);

    // fetch only
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    txn("fetch", O_INSTR, 32'h100, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF);
    instr_req_i = 1'b0;

    // all three at once: store, load, fetch
    instr_req_i = 1'b1; instr_addr_i = 32'h110;
    rdata_req_i = 1'b1; rdata_addr_i = 32'h220; rdata_strb_i = 4'h3;
    wdata_req_i = 1'b1; wdata_addr_i = 32'h330; wdata_data_i = 32'h1111_2222; wdata_strb_i = 4'hE;
    txn("pri_w", O_WDATA, 32'h330, 1'b1, 32'h1111_2222, 4'hE, 32'h0);
    wdata_req_i = 1'b0;
    txn("pri_r", O_RDATA, 32'h220, 1'b0, 32'h0, 4'h3, 32'hA5A5_0001);
    rdata_req_i = 1'b0;
    txn("pri_i", O_INSTR, 32'h110, 1'b0, 32'h0, 4'hF, 32'hA5A5_0002);
    instr_req_i = 1'b0;

    // starvation: fetch wins every 5th arbitration against a continuous store
    instr_req_i = 1'b1; instr_addr_i = 32'h140;
    wdata_req_i = 1'b1; wdata_addr_i = 32'h340; wdata_data_i = 32'h0BAD_CAFE; wdata_strb_i = 4'hF;
    for (int i = 1; i <= 10; i++) begin
      if (i % 5 == 0) txn("starve_i", O_INSTR, 32'h140, 1'b0, 32'h0, 4'hF, i);
      else            txn("starve_w", O_WDATA, 32'h340, 1'b1, 32'h0BAD_CAFE, 4'hF, i);
    end
    instr_req_i = 1'b0; wdata_req_i = 1'b0;

    // grant withheld 10 cycles; requester drops and changes payload meanwhile
    wdata_req_i = 1'b1; wdata_addr_i = 32'h300; wdata_data_i = 32'hCAFE_F00D; wdata_strb_i = 4'hC;
    @(posedge clk_i); #1;
    wdata_req_i = 1'b0; wdata_addr_i = 32'hFFFF_FFFF; wdata_data_i = 32'h0; wdata_strb_i = 4'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_req", mem_req_o, 1);
      chk("stall_addr", mem_addr_o, 32'h300);
      chk("stall_wdata", mem_wdata_o, 32'hCAFE_F00D);
      chk("stall_strb_we", {mem_strb_o, mem_we_o}, {4'hC, 1'b1});
      chk("stall_ready", {instr_ready_o, rdata_ready_o, wdata_ready_o}, 0);
      @(posedge clk_i); #1;
    end
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #1;
    chk("stall_done", {wdata_ready_o, wdata_valid_o, rdata_valid_o, instr_valid_o}, 4'b1100);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #1 chk("stall_idle", arb_busy_o, 0);

    // load with grant and rvalid in the same cycle
    rdata_req_i = 1'b1; rdata_addr_i = 32'h400; rdata_strb_i = 4'h1;
    @(posedge clk_i); #1;
    rdata_req_i = 1'b0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    #1;
    chk("fast_rdy_vld", {rdata_ready_o, rdata_valid_o, instr_valid_o, wdata_valid_o}, 4'b1100);
    chk("fast_data", rdata_data_o, 32'h1234_5678);
    chk("fast_payload", {mem_addr_o, mem_strb_o, mem_we_o}, {32'h400, 4'h1, 1'b0});
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #1 chk("fast_idle", arb_busy_o, 0);

    // reset during RESP, then a late rvalid
    instr_req_i = 1'b1; instr_addr_i = 32'h500;
    @(posedge clk_i); #1;
    instr_req_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    chk("rresp_busy", arb_busy_o, 1);
    rstn_i = 1'b0; mem_rvalid_i = 1'b1;
    #1;
    chk("rresp_async", {arb_busy_o, mem_req_o}, 0);
    chk("rresp_valid", {instr_valid_o, rdata_valid_o, wdata_valid_o}, 0);
    chk("rresp_addr", mem_addr_o, 0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    #1;
    chk("late_valid", {instr_valid_o, rdata_valid_o, wdata_valid_o}, 0);
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0;
    chk("late_busy", {arb_busy_o, mem_req_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
